fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the main/ALU decoder.
//  Holds the PC and issues word fetches to instruction memory over a valid/ready request + in-order response port.
//  Buffers returned words in a small FIFO and presents them, with their PC, to decode via valid/ready.
//  Flushes and redirects on PCSrc (branch or write to R15) from conditional logic.
// PARAMETERS
//  ADDR_W      32       PC / memory address width
//  RESET_PC    32'h0    PC loaded on reset (word aligned)
//  DEPTH       2        instruction FIFO entries; also max in-flight + buffered fetches (>=2, power of 2)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-low reset
//  imem_req_valid out  1       fetch request valid
//  imem_req_ready in   1       memory accepts request this cycle
//  imem_addr      out  ADDR_W  fetch address (= PC), bits[1:0] always 0
//  imem_rsp_valid in   1       response word valid (in order, 1 per accepted request, latency >=1)
//  imem_rsp_data  in   32      response instruction word
//  pc_src         in   1       redirect strobe (PCSrc)
//  pc_target      in   ADDR_W  redirect address; bits[1:0] ignored
//  instr_valid    out  1       FIFO head valid toward decode
//  instr_ready    in   1       decode consumes head this cycle
//  instr          out  32      head instruction; decode takes Op/Funct/Rd fields from it
//  instr_pc       out  ADDR_W  address of head instruction
//  instr_pc8      out  ADDR_W  instr_pc + 8 (R15 read value)
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req_valid=0, instr_valid=0,
//   imem_addr=RESET_PC, instr/instr_pc=0. Requests may start the first clock edge after deassertion.
//  Credit: imem_req_valid = !pc_src && (fifo_count + outstanding < DEPTH). Combinational from regs + pc_src only.
//  Accept (req_valid & req_ready): pc <= pc+4 (wraps modulo 2^ADDR_W), outstanding++.
//  imem_addr/valid held stable while valid & !ready, except when pc_src withdraws the request.
//  Response: outstanding--; if drop>0 then drop-- and word discarded; else word+its PC pushed to FIFO tail.
//   Pushed word is visible at head no earlier than the next cycle (no bypass). Min fetch->instr_valid latency 2 cycles.
//  Credit rule guarantees FIFO never overflows; a response arriving with FIFO full is impossible.
//  Pop: instr_valid & instr_ready removes head. Push and pop same cycle: count unchanged, both take effect.
//  Accept and response same cycle: outstanding unchanged.
//  Redirect (pc_src=1, single-cycle strobe, level also legal):
//   - pc <= {pc_target[ADDR_W-1:2],2'b00}; FIFO cleared; concurrent pop ignored.
//   - drop <= outstanding remaining after this cycle's response (i.e. responses still owed are discarded);
//     a response arriving in the redirect cycle is discarded.
//   - no request issued in redirect cycle; instr_valid=0 the cycle after.
//   - redirect while drop>0: drop accumulates correctly (drop = all owed responses).
//  instr_valid = FIFO non-empty; instr, instr_pc, instr_pc8 stable while instr_valid & !instr_ready.
//  Per-entry PC stored in FIFO (not recomputed); instr_pc8 = instr_pc+8, wraps.
//  Counters: outstanding, drop are clog2(DEPTH)+1 bits; fifo pointers wrap at DEPTH.
//  Reset asserted mid-operation: all state cleared immediately; late memory responses after reset release
//   are the memory's responsibility (memory must be reset together).
// TESTING
//  1 Reset release, mem ready=1, 1-cycle latency, words 0xE0800001,.. ; decode ready=1 -> addrs 0,4,8,..; instr_valid from cycle 2; instr_pc 0,4,8 in order.
//  2 instr_ready=0 for 10 cycles -> exactly DEPTH requests issued, FIFO full, imem_req_valid=0; on ready=1 words drain in order, no loss/dup.
//  3 pc_src=1, pc_target=0x103 with 2 fetches outstanding -> FIFO cleared, next addr 0x100, both stale responses dropped, first instr_pc=0x100.
//  4 Redirect in same cycle as response and pop -> response dropped, pop ignored, instr_valid=0 next cycle.
//  5 RESET_PC=32'hFFFFFFF8 -> addrs FFFFFFF8, FFFFFFFC, 00000000; instr_pc8 of FFFFFFFC = 00000004.
//  6 imem_req_ready random, rsp latency random 1-4, random redirects -> scoreboard: decode sees exactly the sequential stream from each redirect target.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem fetch, in-order instruction FIFO toward decode, redirect on pc_src
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc8
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] pc, rsp_pc, tgt;
  logic [31:0]       buf_d  [DEPTH];
  logic [ADDR_W-1:0] buf_pc [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt, outs, drop;
  logic [CW:0]       used;
  logic              accept, push, pop;
  assign tgt            = pc_target & ~ADDR_W'(3);
  assign used           = {1'b0, cnt} + {1'b0, outs};
  assign imem_req_valid = reset && !pc_src && (used < (CW+1)'(DEPTH));
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop == '0) && !pc_src;
  assign pop            = instr_valid && instr_ready && !pc_src;
  assign instr_valid    = cnt != '0;
  assign instr          = buf_d[rp];
  assign instr_pc       = buf_pc[rp];
  assign instr_pc8      = instr_pc + ADDR_W'(8);
  // rsp_pc tracks the address of the next response that will be kept, so stale drops never advance it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      outs   <= '0;
      drop   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_d[i]  <= '0;
        buf_pc[i] <= '0;
      end
    end else begin
      outs <= outs + CW'(accept) - CW'(imem_rsp_valid);
      if (pc_src) begin
        pc     <= tgt;
        rsp_pc <= tgt;
        wp     <= '0;
        rp     <= '0;
        cnt    <= '0;
        drop   <= outs - CW'(imem_rsp_valid);
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          buf_d[wp]  <= imem_rsp_data;
          buf_pc[wp] <= rsp_pc;
          wp         <= wp + PW'(1);
          rsp_pc     <= rsp_pc + ADDR_W'(4);
        end
        if (pop) rp <= rp + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an imem model and an in-order decode scoreboard
module tb_fetch_unit;
  logic        clk = 0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, pc_src, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rsp_data, pc_target, instr, instr_pc, instr_pc8;
  logic        req_valid_b, rsp_valid_b, instr_valid_b;
  logic        req_ready_b = 1, instr_ready_b = 1;
  logic [31:0] addr_b, rsp_data_b, instr_b, instr_pc_b, instr_pc8_b;
  int n_chk = 0, n_pass = 0, n_pop = 0, acc = 0, cyc = 0;
  int lat_min = 1, lat_max = 1, a0, p0;
  logic rdy_rand = 0, b_pend = 0;
  logic [31:0] exp_pc = 0, b_addr_l = 0, pc8_seen = 0;
  logic [31:0] b_log [3];
  int b_n = 0;
  typedef struct {logic [31:0] a; int due;} ent_t;
  ent_t q[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_src(pc_src), .pc_target(pc_target), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b),
    .imem_addr(addr_b), .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
    .pc_src(1'b0), .pc_target(32'h0), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
    .instr(instr_b), .instr_pc(instr_pc_b), .instr_pc8(instr_pc8_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hE080_0001 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // memory model: accepts/consumes are committed at the negedge before the edge that performs them
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      b_pend = 0;
    end else begin
      if (imem_rsp_valid) void'(q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        q.push_back('{imem_addr, cyc + $urandom_range(lat_min, lat_max)});
        acc++;
      end
      b_pend = req_valid_b && req_ready_b;
      if (b_pend) begin
        b_addr_l = addr_b;
        if (b_n < 3) b_log[b_n] = addr_b;
        b_n++;
      end
      if (instr_valid_b && instr_ready_b && instr_pc_b == 32'hFFFF_FFFC) pc8_seen = instr_pc8_b;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_rsp_valid = reset && q.size() > 0 && q[0].due <= cyc;
    imem_rsp_data  = imem_rsp_valid ? word(q[0].a) : 32'h0;
    rsp_valid_b    = reset && b_pend;
    rsp_data_b     = word(b_addr_l);
  end

  // decode-side scoreboard: every consumed word must continue the sequential stream from the last redirect
  always @(negedge clk) begin
    if (!reset) exp_pc = 0;
    else if (pc_src) exp_pc = pc_target & ~32'h3;
    else if (instr_valid && instr_ready) begin
      chk("sb_pc", instr_pc, exp_pc);
      chk("sb_instr", instr, word(exp_pc));
      chk("sb_pc8", instr_pc8, exp_pc + 8);
      exp_pc += 4;
      n_pop++;
    end
  end

  initial begin
    reset = 0; pc_src = 0; pc_target = 0; instr_ready = 1;
    imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0; rsp_valid_b = 0; rsp_data_b = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_addr_b", addr_b, 32'hFFFF_FFF8);
    reset = 1;
    #1;
    chk("t1_req0", imem_req_valid, 1);
    chk("t1_addr0", imem_addr, 0);
    tick;
    chk("t1_addr1", imem_addr, 4);
    chk("t1_nobypass", instr_valid, 0);
    tick;
    chk("t1_valid_c2", instr_valid, 1);
    chk("t1_pc0", instr_pc, 0);
    chk("t1_word0", instr, 32'hE080_0001);
    chk("t1_pc8", instr_pc8, 8);
    repeat (20) tick;
    // decode stall: credit must cap issue at DEPTH
    pc_src = 1; pc_target = 32'h40; instr_ready = 0;
    tick;
    pc_src = 0; a0 = acc;
    repeat (10) tick;
    chk("t2_reqs", acc - a0, 2);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_full_valid", instr_valid, 1);
    chk("t2_head_pc", instr_pc, 32'h40);
    chk("t2_head_word", instr, 32'hE080_0011);
    instr_ready = 1;
    tick;
    chk("t2_next_pc", instr_pc, 32'h44);
    repeat (5) tick;
    // redirect with two fetches owed
    lat_min = 4; lat_max = 4;
    pc_src = 1; pc_target = 32'h200;
    tick;
    pc_src = 0; a0 = acc;
    for (int i = 0; i < 20 && acc - a0 < 2; i++) tick;
    chk("t3_two_owed", acc - a0, 2);
    pc_src = 1; pc_target = 32'h103;
    #1;
    chk("t3_redir_noreq", imem_req_valid, 0);
    tick;
    pc_src = 0;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_cleared", instr_valid, 0);
    for (int i = 0; i < 30 && !instr_valid; i++) tick;
    chk("t3_valid", instr_valid, 1);
    chk("t3_first_pc", instr_pc, 32'h100);
    chk("t3_first_word", instr, 32'hE080_0041);
    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30 && !(instr_valid && imem_rsp_valid); i++) tick;
    chk("t4_setup", instr_valid && imem_rsp_valid, 1);
    pc_src = 1; pc_target = 32'h300;
    tick;
    pc_src = 0;
    chk("t4_valid_off", instr_valid, 0);
    chk("t4_addr", imem_addr, 32'h300);
    for (int i = 0; i < 30 && !instr_valid; i++) tick;
    chk("t4_first_pc", instr_pc, 32'h300);
    // wrap instance
    chk("t5_addr0", b_log[0], 32'hFFFF_FFF8);
    chk("t5_addr1", b_log[1], 32'hFFFF_FFFC);
    chk("t5_addr2", b_log[2], 32'h0000_0000);
    chk("t5_pc8_wrap", pc8_seen, 32'h4);
    // random traffic, scoreboard checks every consumed word
    rdy_rand = 1; lat_min = 1; lat_max = 4; p0 = n_pop;
    repeat (1500) begin
      tick;
      pc_src = $urandom_range(0, 19) == 0;
      pc_target = $urandom_range(0, 32'hFFFF);
      instr_ready = $urandom_range(0, 3) != 0;
    end
    pc_src = 0;
    chk("t6_progress", n_pop - p0 > 50, 1);
    // asynchronous reset mid-stream
    #3 reset = 0;
    #1;
    chk("rst2_req_valid", imem_req_valid, 0);
    chk("rst2_instr_valid", instr_valid, 0);
    chk("rst2_addr", imem_addr, 0);
    chk("rst2_instr_pc", instr_pc, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
